// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with three-pin enable and built-in address sequencer
// (static, scan up, scan down, one-shot sweep) paced by a dwell prescaler.
module decoder_scan_n #(
  parameter int ADDR_W  = 3,
  parameter bit ACT_LOW = 1'b1,
  parameter int DIV_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     g1,
  input  logic                     g2a_n,
  input  logic                     g2b_n,
  input  logic [1:0]               mode,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DIV_W-1:0]         dwell,
  output logic [(1<<ADDR_W)-1:0]   y,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     wrap,
  output logic                     done,
  output logic [2:0]               state_dbg
);

  localparam int NOUT = 1 << ADDR_W;
  localparam logic [NOUT-1:0] INACT = {NOUT{ACT_LOW}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STATIC = 3'd1,
    S_UP     = 3'd2,
    S_DN     = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [DIV_W-1:0]    presc_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [NOUT-1:0]     y_q;
  logic                wrap_q;
  logic                done_q;

  logic                sel;
  logic                entry;
  logic                expire;
  logic [ADDR_W-1:0]   addr_up;
  logic [ADDR_W-1:0]   addr_dn;
  logic                at_top;
  logic                at_bot;
  state_t              entry_state;

  function automatic logic [NOUT-1:0] dec(input logic [ADDR_W-1:0] a);
    logic [NOUT-1:0] oh;
    oh    = '0;
    oh[a] = 1'b1;
    return ACT_LOW ? ~oh : oh;
  endfunction

  assign sel     = g1 & ~g2a_n & ~g2b_n;
  // Leaving reset counts as a mode entry, so IDLE is treated like a mode change.
  assign entry   = (state_q == S_IDLE) || (mode != mode_q);
  assign expire  = (presc_q >= dwell);
  assign addr_up = cur_addr_q + 1'b1;
  assign addr_dn = cur_addr_q - 1'b1;
  assign at_top  = &cur_addr_q;
  assign at_bot  = ~|cur_addr_q;

  always_comb begin
    entry_state = S_STATIC;
    case (mode)
      2'b00:   entry_state = S_STATIC;
      2'b01:   entry_state = S_UP;
      2'b10:   entry_state = S_DN;
      default: entry_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      presc_q    <= '0;
      cur_addr_q <= '0;
      y_q        <= INACT;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (!sel) begin
      y_q    <= INACT;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (entry) begin
        mode_q     <= mode;
        state_q    <= entry_state;
        presc_q    <= '0;
        cur_addr_q <= addr;
        y_q        <= dec(addr);
      end else begin
        case (state_q)
          S_STATIC: begin
            presc_q    <= '0;
            cur_addr_q <= addr;
            y_q        <= dec(addr);
          end
          S_UP, S_DN, S_RUN: begin
            if (!expire) begin
              presc_q <= presc_q + 1'b1;
              y_q     <= dec(cur_addr_q);
            end else begin
              presc_q <= '0;
              if (state_q == S_UP) begin
                cur_addr_q <= addr_up;
                y_q        <= dec(addr_up);
                wrap_q     <= at_top;
              end else if (state_q == S_DN) begin
                cur_addr_q <= addr_dn;
                y_q        <= dec(addr_dn);
                wrap_q     <= at_bot;
              end else if (at_top) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                y_q     <= INACT;
              end else begin
                cur_addr_q <= addr_up;
                y_q        <= dec(addr_up);
              end
            end
          end
          default: y_q <= INACT;
        endcase
      end
    end
  end

  assign y         = y_q;
  assign cur_addr  = cur_addr_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
